// File: rtl/dm_trial_scheduler_if.sv
// Signal bundle between the DM trial scheduler and its surroundings
// (register block, datapath strobe, delay-bank command bus).
//
// Handshake: coef_wr_en, start and abort are single-cycle strobes sampled on
// the rising edge of clk_data with no back-pressure (no ready). data_in_valid
// qualifies one datapath sample per cycle. trial_done and sweep_done are
// single-cycle pulses. cmd_ch_dly changes for all lanes on one edge only.
// dbg_state exposes the scheduler FSM encoding for observation.
interface dm_trial_scheduler_if #(
  parameter int CMD_WIDTH   = 32,
  parameter int NOF_CHANNEL = 128,
  parameter int DM_WIDTH    = 16,
  parameter int COEF_WIDTH  = 16,
  parameter int DWELL_WIDTH = 24
);
  localparam int NCH    = NOF_CHANNEL / 2;
  localparam int LANE_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic                     coef_wr_en;
  logic [LANE_W-1:0]        coef_addr;
  logic [COEF_WIDTH-1:0]    coef_data;
  logic                     start;
  logic                     abort;
  logic [DM_WIDTH-1:0]      dm_start;
  logic [DM_WIDTH-1:0]      dm_step;
  logic [15:0]              nof_dm;
  logic [DWELL_WIDTH-1:0]   dwell_len;
  logic                     data_in_valid;
  logic [CMD_WIDTH*NCH-1:0] cmd_ch_dly;
  logic [15:0]              dm_idx;
  logic                     busy;
  logic                     trial_active;
  logic                     trial_done;
  logic                     sweep_done;
  logic [2:0]               dbg_state;

  modport master (
    output coef_wr_en, coef_addr, coef_data, start, abort,
    output dm_start, dm_step, nof_dm, dwell_len, data_in_valid,
    input  cmd_ch_dly, dm_idx, busy, trial_active, trial_done, sweep_done,
    input  dbg_state
  );

  modport slave (
    input  coef_wr_en, coef_addr, coef_data, start, abort,
    input  dm_start, dm_step, nof_dm, dwell_len, data_in_valid,
    output cmd_ch_dly, dm_idx, busy, trial_active, trial_done, sweep_done,
    output dbg_state
  );
endinterface

// File: rtl/dm_trial_scheduler.sv
// DM trial scheduler: steps the de-dispersion delay bank through a sweep of
// dispersion-measure trials. Per trial it computes one delay per lane
// (dm * coef >> COEF_FRAC, saturated at MAX_DELAY) into a shadow register,
// publishes all lanes at once, waits SETTLE_CYCLES, then dwells for
// dwell_len valid samples before moving on.
// Optional feature macro: DM_TRIAL_SCHED_LOOP_EN -- when defined the sweep
// wraps back to the first DM after the last trial and repeats until abort.
// SETTLE_CYCLES is expected to be at least 1.
module dm_trial_scheduler #(
  parameter int CMD_WIDTH     = 32,
  parameter int NOF_CHANNEL   = 128,
  parameter int DM_WIDTH      = 16,
  parameter int COEF_WIDTH    = 16,
  parameter int COEF_FRAC     = 8,
  parameter int MAX_DELAY     = 4095,
  parameter int SETTLE_CYCLES = 4,
  parameter int DWELL_WIDTH   = 24
) (
  input  logic          clk_data,
  input  logic          rst_n,
  dm_trial_scheduler_if.slave bus
);
  localparam int NCH    = NOF_CHANNEL / 2;
  localparam int LANE_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW     = DM_WIDTH + COEF_WIDTH;
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int VEC_W  = CMD_WIDTH * NCH;
  localparam logic [PW-1:0] MAX_D = PW'(MAX_DELAY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_APPLY  = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_NEXT   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [COEF_WIDTH-1:0]  coef_q [NCH];
  logic [COEF_WIDTH-1:0]  coef_d [NCH];
  logic [VEC_W-1:0]       shadow_q, shadow_d;
  logic [VEC_W-1:0]       cmd_q, cmd_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_WIDTH-1:0] dwell_len_q, dwell_len_d;
  logic [DM_WIDTH-1:0]    dm_value_q, dm_value_d;
  logic [DM_WIDTH-1:0]    dm_start_q, dm_start_d;
  logic [DM_WIDTH-1:0]    dm_step_q, dm_step_d;
  logic [15:0]            nof_dm_q, nof_dm_d;
  logic [15:0]            dm_idx_q, dm_idx_d;
  logic                   busy_q, busy_d;
  logic                   trial_active_q, trial_active_d;
  logic                   sweep_done_q, sweep_done_d;

  // Lane delay arithmetic for the lane currently being processed in CALC.
  logic [PW-1:0]          prod;
  logic [PW-1:0]          dly;
  logic [CMD_WIDTH-1:0]   lane_cmd;
  logic [DM_WIDTH:0]      dm_sum;
  logic [DM_WIDTH-1:0]    dm_next;
  logic [DWELL_WIDTH-1:0] dwell_last;
  logic                   last_valid;

  assign prod     = PW'(dm_value_q) * PW'(coef_q[lane_q]);
  assign dly      = prod >> COEF_FRAC;
  assign lane_cmd = (dly > MAX_D) ? CMD_WIDTH'(MAX_DELAY) : CMD_WIDTH'(dly);

  // DM stepping saturates at the top of the DM range instead of wrapping.
  assign dm_sum  = {1'b0, dm_value_q} + {1'b0, dm_step_q};
  assign dm_next = dm_sum[DM_WIDTH] ? '1 : dm_sum[DM_WIDTH-1:0];

  // A dwell length of zero behaves as a dwell of one sample.
  assign dwell_last = (dwell_len_q == '0) ? '0 : dwell_len_q - DWELL_WIDTH'(1);
  assign last_valid = bus.data_in_valid && (dwell_cnt_q == dwell_last);

  // Next-state and datapath update for the whole scheduler.
  always_comb begin
    state_d        = state_q;
    coef_d         = coef_q;
    shadow_d       = shadow_q;
    cmd_d          = cmd_q;
    lane_d         = lane_q;
    settle_d       = settle_q;
    dwell_cnt_d    = dwell_cnt_q;
    dwell_len_d    = dwell_len_q;
    dm_value_d     = dm_value_q;
    dm_start_d     = dm_start_q;
    dm_step_d      = dm_step_q;
    nof_dm_d       = nof_dm_q;
    dm_idx_d       = dm_idx_q;
    sweep_done_d   = 1'b0;

    if (state_q == S_IDLE && bus.coef_wr_en) begin
      coef_d[bus.coef_addr] = bus.coef_data;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dm_start_d  = bus.dm_start;
          dm_step_d   = bus.dm_step;
          nof_dm_d    = bus.nof_dm;
          dwell_len_d = bus.dwell_len;
          if (bus.nof_dm == 16'd0) begin
            sweep_done_d = 1'b1;
          end else begin
            dm_value_d = bus.dm_start;
            dm_idx_d   = 16'd0;
            lane_d     = '0;
            state_d    = S_CALC;
          end
        end
      end
      S_CALC: begin
        shadow_d[lane_q*CMD_WIDTH +: CMD_WIDTH] = lane_cmd;
        if (lane_q == LANE_W'(NCH-1)) begin
          state_d = S_APPLY;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
      S_APPLY: begin
        cmd_d    = shadow_q;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES-1)) begin
          dwell_cnt_d = '0;
          state_d     = S_RUN;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_RUN: begin
        if (bus.data_in_valid) begin
          if (last_valid) begin
            state_d = S_NEXT;
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_WIDTH'(1);
          end
        end
      end
      S_NEXT: begin
        if (dm_idx_q == nof_dm_q - 16'd1) begin
          sweep_done_d = 1'b1;
`ifdef DM_TRIAL_SCHED_LOOP_EN
          dm_idx_d   = 16'd0;
          dm_value_d = dm_start_q;
          lane_d     = '0;
          state_d    = S_CALC;
`else
          state_d    = S_IDLE;
`endif
        end else begin
          dm_idx_d   = dm_idx_q + 16'd1;
          dm_value_d = dm_next;
          lane_d     = '0;
          state_d    = S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything else; published delays are left untouched.
    if (bus.abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      cmd_d        = cmd_q;
      sweep_done_d = 1'b1;
    end

    busy_d         = (state_d != S_IDLE);
    trial_active_d = (state_d == S_RUN);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < NCH; i++) coef_q[i] <= '0;
      shadow_q       <= '0;
      cmd_q          <= '0;
      lane_q         <= '0;
      settle_q       <= '0;
      dwell_cnt_q    <= '0;
      dwell_len_q    <= '0;
      dm_value_q     <= '0;
      dm_start_q     <= '0;
      dm_step_q      <= '0;
      nof_dm_q       <= '0;
      dm_idx_q       <= '0;
      busy_q         <= 1'b0;
      trial_active_q <= 1'b0;
      sweep_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      coef_q         <= coef_d;
      shadow_q       <= shadow_d;
      cmd_q          <= cmd_d;
      lane_q         <= lane_d;
      settle_q       <= settle_d;
      dwell_cnt_q    <= dwell_cnt_d;
      dwell_len_q    <= dwell_len_d;
      dm_value_q     <= dm_value_d;
      dm_start_q     <= dm_start_d;
      dm_step_q      <= dm_step_d;
      nof_dm_q       <= nof_dm_d;
      dm_idx_q       <= dm_idx_d;
      busy_q         <= busy_d;
      trial_active_q <= trial_active_d;
      sweep_done_q   <= sweep_done_d;
    end
  end

  // trial_done must coincide with the final valid sample, so it is decoded
  // from the current state and inputs rather than registered.
  assign bus.trial_done   = (state_q == S_RUN) && last_valid && !bus.abort;
  assign bus.cmd_ch_dly   = cmd_q;
  assign bus.dm_idx       = dm_idx_q;
  assign bus.busy         = busy_q;
  assign bus.trial_active = trial_active_q;
  assign bus.sweep_done   = sweep_done_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_dm_trial_scheduler.sv
// Self-checking bench for dm_trial_scheduler.
module tb_dm_trial_scheduler;
  localparam int NCH    = 64;
  localparam int CMD_W  = 32;
  localparam int VEC_W  = CMD_W * NCH;
  localparam int SETTLE = 4;

  logic clk_data = 1'b0;
  logic rst_n    = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   tb_coef [NCH];

  dm_trial_scheduler_if bus ();
  dm_trial_scheduler dut (.clk_data(clk_data), .rst_n(rst_n), .bus(bus));

  always #5 clk_data = ~clk_data;

  typedef struct {
    int lane;
    int coef;
    int dm;
    int exp_dly;
  } vec_t;

  task automatic tick();
    @(posedge clk_data);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int m = NCH-1; m >= 0; m--)
      if (act[m*CMD_W +: CMD_W] !== exp[m*CMD_W +: CMD_W]) bad = m;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: lane %0d got %0d expected %0d", name, bad,
               act[bad*CMD_W +: CMD_W], exp[bad*CMD_W +: CMD_W]);
    end
  endtask

  // Reference: trial k uses dm = min(dm_start + k*dm_step, 65535); every lane
  // gets min(floor(dm*coef/256), 4095).
  function automatic logic [VEC_W-1:0] exp_vec(input int ds, input int st, input int k);
    logic [VEC_W-1:0] v;
    longint dm, d;
    v  = '0;
    dm = longint'(ds) + longint'(k) * longint'(st);
    if (dm > 65535) dm = 65535;
    for (int m = 0; m < NCH; m++) begin
      d = (dm * longint'(tb_coef[m])) / 256;
      if (d > 4095) d = 4095;
      v[m*CMD_W +: CMD_W] = CMD_W'(d);
    end
    return v;
  endfunction

  task automatic write_coef(input int lane, input int val);
    bus.coef_wr_en = 1'b1;
    bus.coef_addr  = 6'(lane);
    bus.coef_data  = 16'(val);
    tick();
    bus.coef_wr_en = 1'b0;
    tb_coef[lane]  = val & 16'hFFFF;
  endtask

  // Runs one sweep and checks every trial against the reference.
  // vmode: 0 valid every cycle, 1 every other cycle, 2 random.
  // abort_cyc < 0 means no abort; exp_pub = trials whose delays get published.
  task automatic run_sweep(input int ds, input int st, input int nd, input int dl,
                           input int vmode, input int abort_cyc, input int exp_td,
                           input int exp_pub, output int n_chg);
    int n_td, vcnt, sd_cyc, dl1, per, budget, cyc;
    logic [VEC_W-1:0] prev;
    dl1    = (dl == 0) ? 1 : dl;
    per    = NCH + 1 + SETTLE + dl1 + 1;
    budget = nd * (per + 20 * dl1 + 20) + 20;
    n_chg  = 0;
    n_td   = 0;
    vcnt   = 0;
    sd_cyc = -1;
    prev   = bus.cmd_ch_dly;
    bus.dm_start  = 16'(ds);
    bus.dm_step   = 16'(st);
    bus.nof_dm    = 16'(nd);
    bus.dwell_len = 24'(dl);
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (cyc = 0; cyc < budget && sd_cyc < 0; cyc++) begin
      case (vmode)
        0:       bus.data_in_valid = 1'b1;
        1:       bus.data_in_valid = cyc[0];
        default: bus.data_in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.abort = (cyc == abort_cyc);
      // While busy: a second start with junk config and a coefficient write
      // must both be ignored.
      bus.start      = (cyc == 5);
      bus.coef_wr_en = (cyc == 7);
      if (cyc == 5) begin
        bus.dm_start  = 16'($urandom);
        bus.dm_step   = 16'($urandom);
        bus.nof_dm    = 16'($urandom_range(1, 9));
        bus.dwell_len = 24'($urandom_range(0, 9));
      end
      if (cyc == 7) begin
        bus.coef_addr = 6'd0;
        bus.coef_data = ~16'(tb_coef[0]);
      end
      @(negedge clk_data);
      if (bus.cmd_ch_dly !== prev) begin
        n_chg++;
        check_vec("cmd_publish", bus.cmd_ch_dly, exp_vec(ds, st, n_td));
        prev = bus.cmd_ch_dly;
      end
      if (bus.trial_active && bus.data_in_valid) vcnt++;
      if (bus.trial_done) begin
        check("td_active", 64'(bus.trial_active), 64'(1));
        check("td_valids", 64'(vcnt), 64'(dl1));
        check("td_dm_idx", 64'(bus.dm_idx), 64'(n_td));
        check_vec("td_cmd", bus.cmd_ch_dly, exp_vec(ds, st, n_td));
        if (vmode == 0) check("td_cycle", 64'(cyc), 64'(n_td * per + NCH + 1 + SETTLE + dl1 - 1));
        vcnt = 0;
        n_td++;
      end
      if (bus.sweep_done) sd_cyc = cyc;
      tick();
    end
    bus.data_in_valid = 1'b0;
    bus.abort         = 1'b0;
    bus.start         = 1'b0;
    bus.coef_wr_en    = 1'b0;
    check("sweep_done_seen", 64'(sd_cyc >= 0), 64'(1));
    if (abort_cyc >= 0) check("abort_sd_cycle", 64'(sd_cyc), 64'(abort_cyc + 1));
    check("trial_count", 64'(n_td), 64'(exp_td));
    @(negedge clk_data);
    check("sd_one_cycle", 64'(bus.sweep_done), 64'(0));
    check("idle_busy", 64'(bus.busy), 64'(0));
    check("idle_active", 64'(bus.trial_active), 64'(0));
    if (exp_pub > 0) check_vec("cmd_hold", bus.cmd_ch_dly, exp_vec(ds, st, exp_pub - 1));
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd"}, 64'(bus.cmd_ch_dly != '0), 64'(0));
    check({tag, "_dm_idx"}, 64'(bus.dm_idx), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_active"}, 64'(bus.trial_active), 64'(0));
    check({tag, "_trial_done"}, 64'(bus.trial_done), 64'(0));
    check({tag, "_sweep_done"}, 64'(bus.sweep_done), 64'(0));
  endtask

  initial begin
    vec_t vt [10];
    int   n_chg;
    bit   seen_run;

    vt[0] = '{lane: 0,  coef: 256,     dm: 3,       exp_dly: 3};
    vt[1] = '{lane: 5,  coef: 'hFFFF,  dm: 'hFFFF,  exp_dly: 4095};
    vt[2] = '{lane: 1,  coef: 'h0180,  dm: 7,       exp_dly: 10};
    vt[3] = '{lane: 2,  coef: 1,       dm: 255,     exp_dly: 0};
    vt[4] = '{lane: 2,  coef: 1,       dm: 256,     exp_dly: 1};
    vt[5] = '{lane: 63, coef: 'h1000,  dm: 255,     exp_dly: 4080};
    vt[6] = '{lane: 63, coef: 'h1000,  dm: 256,     exp_dly: 4095};
    vt[7] = '{lane: 7,  coef: 0,       dm: 'hFFFF,  exp_dly: 0};
    vt[8] = '{lane: 10, coef: 'h0FFF,  dm: 256,     exp_dly: 4095};
    vt[9] = '{lane: 11, coef: 'h1001,  dm: 255,     exp_dly: 4080};

    for (int m = 0; m < NCH; m++) tb_coef[m] = 0;
    bus.coef_wr_en = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.data_in_valid = 1'b0;
    bus.dm_start = '0; bus.dm_step = '0; bus.nof_dm = '0; bus.dwell_len = '0;

    // Reset values.
    repeat (2) @(posedge clk_data);
    #1;
    check_all_zero("reset");
    @(posedge clk_data);
    #1 rst_n = 1'b1;

    // Abort while idle does nothing.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk_data);
    check("idle_abort_sd", 64'(bus.sweep_done), 64'(0));
    check("idle_abort_busy", 64'(bus.busy), 64'(0));
    tick();

    // Table: single-lane delay arithmetic and saturation boundaries.
    for (int i = 0; i < 10; i++) begin
      write_coef(vt[i].lane, vt[i].coef);
      run_sweep(vt[i].dm, 0, 1, 1, 0, -1, 1, 1, n_chg);
      check($sformatf("table_%0d", i), 64'(bus.cmd_ch_dly[vt[i].lane*CMD_W +: CMD_W]), 64'(vt[i].exp_dly));
    end

    // Three-trial sweep with coef[m] = 256*(m+1): lanes 3(m+1), 5(m+1), 7(m+1).
    for (int m = 0; m < NCH; m++) write_coef(m, 256 * (m + 1));
    run_sweep(3, 2, 3, 10, 0, -1, 3, 3, n_chg);
    check("main_publish_count", 64'(n_chg), 64'(3));
    check("main_lane63", 64'(bus.cmd_ch_dly[63*CMD_W +: CMD_W]), 64'(7 * 64));

    // Valid every other cycle, dwell of 4.
    run_sweep(3, 2, 2, 4, 1, -1, 2, 2, n_chg);

    // Abort in the 10th CALC cycle of trial 1: trial-0 delays stay published.
    run_sweep(3, 2, 3, 10, 0, (NCH + 1 + SETTLE + 10 + 1) + 9, 1, 1, n_chg);
    check("abort_lane0", 64'(bus.cmd_ch_dly[0 +: CMD_W]), 64'(3));

    // nof_dm = 0: sweep_done next cycle, never busy.
    bus.nof_dm = 16'd0;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clk_data);
    check("zero_nof_sd", 64'(bus.sweep_done), 64'(1));
    check("zero_nof_busy", 64'(bus.busy), 64'(0));
    tick();
    @(negedge clk_data);
    check("zero_nof_sd_end", 64'(bus.sweep_done), 64'(0));
    check("zero_nof_busy_end", 64'(bus.busy), 64'(0));
    tick();

    // Abort on the final valid of trial 0 suppresses trial_done.
    run_sweep(3, 2, 2, 3, 0, NCH + 1 + SETTLE + 3 - 1, 0, 1, n_chg);

    // dwell_len 0 acts as 1; DM stepping saturates at 0xFFFF.
    for (int m = 0; m < NCH; m++) write_coef(m, m * 8);
    run_sweep('hFFF0, 'h10, 3, 0, 0, -1, 3, 3, n_chg);

    // Randomized sweeps against the reference.
    for (int r = 0; r < 6; r++) begin
      int nd;
      for (int w = 0; w < 16; w++) write_coef($urandom_range(0, NCH-1), $urandom_range(0, 65535));
      nd = $urandom_range(1, 3);
      run_sweep($urandom_range(0, 65535), $urandom_range(0, 8191), nd,
                $urandom_range(0, 6), $urandom_range(0, 2), -1, nd, nd, n_chg);
    end

    // Asynchronous reset in the middle of RUN.
    bus.dm_start = 16'd5; bus.dm_step = 16'd1; bus.nof_dm = 16'd2; bus.dwell_len = 24'd50;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.data_in_valid = 1'b1;
    seen_run = 1'b0;
    for (int c = 0; c < 300 && !seen_run; c++) begin
      @(negedge clk_data);
      if (bus.trial_active) seen_run = 1'b1;
      else tick();
    end
    check("reach_run", 64'(seen_run), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    for (int m = 0; m < NCH; m++) tb_coef[m] = 0;
    bus.data_in_valid = 1'b0;
    repeat (2) @(posedge clk_data);
    #1 rst_n = 1'b1;
    run_sweep(9, 1, 2, 2, 0, -1, 2, 2, n_chg);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_trial_scheduler.md
Name: dm_trial_scheduler

Overview:
- Sequences the de-dispersion channel-delay datapath through a sweep of dispersion-measure (DM) trials.
- For each trial it computes per-channel delays and publishes them atomically on the packed channel-delay command bus.
- It waits for the delay lines to settle, then holds the trial for a programmed number of valid samples before stepping to the next DM.
- Sits in the clk_data domain, directly upstream of the delay bank's command input; coefficients and sweep config come from the register block.

Parameters:
- CMD_WIDTH, 32, width of one channel's delay command.
- NOF_CHANNEL, 128, total channels; the block serves NCH = NOF_CHANNEL/2 lanes.
- DM_WIDTH, 16, width of DM start/step/value.
- COEF_WIDTH, 16, width of per-channel delay coefficient (unsigned fixed point).
- COEF_FRAC, 8, fractional bits of coefficient.
- MAX_DELAY, 4095, saturation ceiling of a delay command (must be <= 2^CMD_WIDTH-1).
- SETTLE_CYCLES, 4, cycles waited after publishing new delays.
- DWELL_WIDTH, 24, width of dwell counter.

Ports:
- clk_data  in  1  data clock, the only clock.
- rst_n  in  1  asynchronous active-low reset.
- coef_wr_en  in  1  coefficient write strobe.
- coef_addr  in  clog2(NCH)  coefficient lane index.
- coef_data  in  COEF_WIDTH  coefficient value.
- start  in  1  one-cycle sweep start.
- abort  in  1  one-cycle sweep abort.
- dm_start  in  DM_WIDTH  first DM value.
- dm_step  in  DM_WIDTH  DM increment per trial.
- nof_dm  in  16  number of trials.
- dwell_len  in  DWELL_WIDTH  valid samples per trial.
- data_in_valid  in  1  sample strobe of the datapath.
- cmd_ch_dly  out  CMD_WIDTH*NCH  packed delays, lane m at [m*CMD_WIDTH +: CMD_WIDTH].
- dm_idx  out  16  current trial index.
- busy  out  1  high outside IDLE.
- trial_active  out  1  high in RUN (data is valid for current DM).
- trial_done  out  1  one-cycle pulse at end of each trial.
- sweep_done  out  1  one-cycle pulse at end of sweep or abort.

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ch_dly=0, dm_idx=0, busy=0, trial_active=0, trial_done=0, sweep_done=0; coefficient array=0.
- Coefficient writes:
  - Accepted only when busy=0; ignored while busy.
  - Coefficient array is internal registers, NCH x COEF_WIDTH.
- FSM states: IDLE, CALC, APPLY, SETTLE, RUN, NEXT.
- IDLE:
  - On start, latch dm_start/dm_step/nof_dm/dwell_len.
  - If nof_dm=0: sweep_done pulses next cycle, stay IDLE.
  - Otherwise: dm_value=dm_start, dm_idx=0, go to CALC.
- CALC:
  - Processes one lane per cycle, lanes 0..NCH-1, taking NCH cycles.
  - Per lane: prod = dm_value*coef[lane] (DM_WIDTH+COEF_WIDTH bits); d = prod >> COEF_FRAC; write min(d, MAX_DELAY) zero-extended to CMD_WIDTH into a shadow register.
  - cmd_ch_dly is unchanged during CALC.
- APPLY: one cycle; shadow copied to cmd_ch_dly (all lanes update on the same edge); go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to RUN with dwell counter cleared.
- RUN:
  - trial_active=1; counter increments on each data_in_valid.
  - When the count reaches dwell_len (dwell_len=0 treated as 1), trial_done pulses in the same cycle as the final valid and the FSM goes to NEXT.
- NEXT:
  - If dm_idx = nof_dm-1: sweep_done pulses, go to IDLE.
  - Else: dm_idx+1, dm_value = dm_value+dm_step saturating at 2^DM_WIDTH-1, go to CALC.
- Trial cycle count: NCH + 1 + SETTLE_CYCLES + dwell cycles + 1.
- abort:
  - In any non-IDLE state, abort forces IDLE on the next edge with sweep_done pulsed once and trial_active=0.
  - cmd_ch_dly retains its last published value; an aborted CALC never publishes.
- Priority and ignored inputs:
  - abort has priority over trial completion in the same cycle; trial_done is not pulsed.
  - start while busy is ignored; abort in IDLE is ignored.
  - Config inputs are sampled only at start.

Optional Feature:
- Macro: DM_TRIAL_SCHED_LOOP_EN.
- Defined: at the end of the last trial, the FSM returns to CALC with dm_idx=0 and dm_value=dm_start, and the sweep repeats until abort. sweep_done pulses at each wrap, concurrent with the NEXT->CALC transition.
- Undefined: the sweep runs once and returns to IDLE.

Test Plan:
- Coefficients coef[m]=256*(m+1), dm_start=3, dm_step=2, nof_dm=3, dwell_len=10 -> the published cmd_ch_dly lane m is 3(m+1), then 5(m+1), then 7(m+1). Three trial_done pulses, one sweep_done, then busy=0.
- Coefficient 0xFFFF on lane 5, dm_start=0xFFFF -> lane 5 = 4095 (saturated); other lanes computed normally.
- Monitor cmd_ch_dly through CALC -> no bit changes until APPLY; all lanes change on one edge.
- data_in_valid toggling every other cycle, dwell_len=4 -> trial_active stays high through exactly 4 valids. trial_done coincides with the 4th valid.
- abort in the 10th cycle of CALC of trial 1 -> next cycle IDLE, sweep_done=1 for one cycle, cmd_ch_dly still holds trial-0 values. Then nof_dm=0 start -> sweep_done one cycle later, busy stays 0.
- Assert rst_n low mid-RUN -> all outputs 0 immediately (asynchronous). A coefficient write during busy -> coefficient unchanged on readback via the next sweep.
